// File: rtl/pattern_history_table.sv
// Second-level local branch predictor: 2-bit saturating counters indexed by {pc bits, local history},
// registered lookup with same-cycle update bypass, and saturating lookup/update/mispredict statistics.
module pattern_history_table #(
    parameter int unsigned HISTORY_BITS  = 4,
    parameter int unsigned PC_INDEX_BITS = 4,
    parameter int unsigned INDEX_BITS    = 8,
    parameter int unsigned TABLE_SIZE    = 256,
    parameter logic [1:0]  COUNTER_INIT  = 2'b01
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    lookup_valid,
    input  logic                    stall,
    input  logic [31:0]             pc,
    input  logic [HISTORY_BITS-1:0] history,
    output logic                    predict_valid,
    output logic                    predict_taken,
    output logic [1:0]              predict_counter,
    input  logic                    update_enable,
    input  logic [31:0]             update_pc,
    input  logic [HISTORY_BITS-1:0] update_history,
    input  logic                    taken,
    input  logic                    mispredicted,
    output logic [31:0]             stat_lookups,
    output logic [31:0]             stat_updates,
    output logic [31:0]             stat_mispredicts
);

    logic [1:0]            r_table [TABLE_SIZE];
    logic                  r_predict_valid;
    logic                  r_predict_taken;
    logic [1:0]            r_predict_counter;
    logic [31:0]           r_stat_lookups;
    logic [31:0]           r_stat_updates;
    logic [31:0]           r_stat_mispredicts;

    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [INDEX_BITS-1:0] w_wr_idx;
    logic                  w_accept;
    logic [1:0]            w_cur;
    logic [1:0]            w_next;
    logic [1:0]            w_lookup_val;
    logic                  w_unused;

    assign w_rd_idx = {pc[PC_INDEX_BITS+1:2], history};
    assign w_wr_idx = {update_pc[PC_INDEX_BITS+1:2], update_history};
    assign w_accept = lookup_valid && !stall;
    assign w_unused = ^{pc[31:PC_INDEX_BITS+2], pc[1:0],
                        update_pc[31:PC_INDEX_BITS+2], update_pc[1:0]};

    always_comb begin
        w_cur  = r_table[w_wr_idx];
        w_next = w_cur;
        if (taken) begin
            if (w_cur != 2'b11) w_next = w_cur + 2'd1;
        end else begin
            if (w_cur != 2'b00) w_next = w_cur - 2'd1;
        end
    end

    // A lookup hitting the entry being trained this edge must see the trained value.
    always_comb begin
        w_lookup_val = r_table[w_rd_idx];
        if (update_enable && (w_rd_idx == w_wr_idx)) w_lookup_val = w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < TABLE_SIZE; i++) r_table[i] <= COUNTER_INIT;
        end else if (update_enable) begin
            r_table[w_wr_idx] <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_predict_valid   <= 1'b0;
            r_predict_taken   <= 1'b0;
            r_predict_counter <= '0;
        end else if (w_accept) begin
            r_predict_valid   <= 1'b1;
            r_predict_taken   <= w_lookup_val[1];
            r_predict_counter <= w_lookup_val;
        end else if (!stall) begin
            r_predict_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_lookups     <= '0;
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_accept && (r_stat_lookups != '1))
                r_stat_lookups <= r_stat_lookups + 32'd1;
            if (update_enable && (r_stat_updates != '1))
                r_stat_updates <= r_stat_updates + 32'd1;
            if (update_enable && mispredicted && (r_stat_mispredicts != '1))
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign predict_valid    = r_predict_valid;
    assign predict_taken    = r_predict_taken;
    assign predict_counter  = r_predict_counter;
    assign stat_lookups     = r_stat_lookups;
    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_pattern_history_table.sv
// Scoreboard bench for pattern_history_table: a behavioural counter-table model pushes expected
// outputs per cycle, which are popped and compared one time unit after the clock edge.
module tb_pattern_history_table;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc = '0;
    logic [3:0]  history = '0;
    logic        predict_valid;
    logic        predict_taken;
    logic [1:0]  predict_counter;
    logic        update_enable = 1'b0;
    logic [31:0] update_pc = '0;
    logic [3:0]  update_history = '0;
    logic        taken = 1'b0;
    logic        mispredicted = 1'b0;
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    pattern_history_table #(
        .HISTORY_BITS (4),
        .PC_INDEX_BITS(4),
        .INDEX_BITS   (8),
        .TABLE_SIZE   (256),
        .COUNTER_INIT (2'b01)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .lookup_valid    (lookup_valid),
        .stall           (stall),
        .pc              (pc),
        .history         (history),
        .predict_valid   (predict_valid),
        .predict_taken   (predict_taken),
        .predict_counter (predict_counter),
        .update_enable   (update_enable),
        .update_pc       (update_pc),
        .update_history  (update_history),
        .taken           (taken),
        .mispredicted    (mispredicted),
        .stat_lookups    (stat_lookups),
        .stat_updates    (stat_updates),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic        t;
        logic [1:0]  c;
        logic [31:0] l;
        logic [31:0] u;
        logic [31:0] m;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  model [256];
    logic        e_v, e_t;
    logic [1:0]  e_c;
    logic [31:0] e_l, e_u, e_m;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = 2'b01;
        e_v = 0; e_t = 0; e_c = 0; e_l = 0; e_u = 0; e_m = 0;
    endtask

    // Drives one cycle, predicts its outcome, then compares after the edge.
    task automatic cycle(input logic lv, input logic st, input logic [31:0] p, input logic [3:0] h,
                         input logic ue, input logic [31:0] upc, input logic [3:0] uh,
                         input logic tk, input logic mp);
        logic [7:0] ri, wi;
        logic [1:0] nv;
        exp_t       x;
        exp_t       y;
        lookup_valid = lv; stall = st; pc = p; history = h;
        update_enable = ue; update_pc = upc; update_history = uh; taken = tk; mispredicted = mp;
        ri = {p[5:2], h};
        wi = {upc[5:2], uh};
        nv = model[wi];
        if (tk && nv != 2'd3) nv = nv + 2'd1;
        else if (!tk && nv != 2'd0) nv = nv - 2'd1;
        if (lv && !st) begin
            e_v = 1'b1;
            e_c = (ue && ri == wi) ? nv : model[ri];
            e_t = e_c[1];
            if (e_l != 32'hFFFFFFFF) e_l++;
        end else if (!st) begin
            e_v = 1'b0;
        end
        if (ue) begin
            model[wi] = nv;
            if (e_u != 32'hFFFFFFFF) e_u++;
            if (mp && e_m != 32'hFFFFFFFF) e_m++;
        end
        x = '{v: e_v, t: e_t, c: e_c, l: e_l, u: e_u, m: e_m};
        sb.push_back(x);
        @(posedge clock);
        #1;
        y = sb.pop_front();
        check("predict_valid", {31'd0, predict_valid}, {31'd0, y.v});
        check("predict_taken", {31'd0, predict_taken}, {31'd0, y.t});
        check("predict_counter", {30'd0, predict_counter}, {30'd0, y.c});
        check("stat_lookups", stat_lookups, y.l);
        check("stat_updates", stat_updates, y.u);
        check("stat_mispredicts", stat_mispredicts, y.m);
    endtask

    task automatic lookup(input logic [31:0] p, input logic [3:0] h);
        cycle(1, 0, p, h, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] p, input logic [3:0] h, input logic tk);
        cycle(0, 0, 0, 0, 1, p, h, tk, 0);
    endtask

    // Asynchronous reset asserted between edges, held across two edges, checked while held.
    task automatic apply_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", {31'd0, predict_valid}, 32'd0);
        check("rst_taken", {31'd0, predict_taken}, 32'd0);
        check("rst_counter", {30'd0, predict_counter}, 32'd0);
        check("rst_lookups", stat_lookups, 32'd0);
        check("rst_updates", stat_updates, 32'd0);
        check("rst_mispredicts", stat_mispredicts, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check("init_valid", {31'd0, predict_valid}, 32'd0);
        check("init_counter", {30'd0, predict_counter}, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;

        lookup(32'h0000_0123, 4'h7);

        // Training to saturation with same-index lookups (bypass gives 2,3,3,3).
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h40, 4'b1010, 1, 32'h40, 4'b1010, 1, 0);
        lookup(32'h40, 4'b1010);
        check("sat_hi", {30'd0, predict_counter}, 32'd3);
        for (int i = 0; i < 5; i++) train(32'h40, 4'b1010, 0);
        lookup(32'h40, 4'b1010);
        check("sat_lo", {30'd0, predict_counter}, 32'd0);

        // Bypass on index {1,3}, then a lookup of a different entry during an update.
        cycle(1, 0, 32'h4, 4'h3, 1, 32'h4, 4'h3, 1, 0);
        check("bypass_hit", {30'd0, predict_counter}, 32'd2);
        cycle(1, 0, 32'h8, 4'h5, 1, 32'h4, 4'h3, 1, 0);
        check("bypass_miss", {30'd0, predict_counter}, 32'd1);
        lookup(32'h4, 4'h3);
        check("after_bypass", {30'd0, predict_counter}, 32'd3);

        // Stall holds everything; idle drops valid only.
        cycle(1, 1, 32'h40, 4'h0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h44, 4'h9, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h8, 4'h5, 0, 0, 0, 0, 0);
        cycle(0, 0, 32'h8, 4'h5, 0, 0, 0, 0, 0);
        check("idle_counter_held", {30'd0, predict_counter}, 32'd3);

        // Independent histories, and aliasing of PC bits above the index.
        train(32'h80, 4'b0000, 1); train(32'h80, 4'b0000, 1);
        train(32'h80, 4'b1111, 0);
        lookup(32'h80, 4'b0000);
        lookup(32'h80, 4'b1111);
        train(32'h440, 4'b0110, 1); train(32'h440, 4'b0110, 1);
        lookup(32'h43, 4'b0110);
        check("alias", {30'd0, predict_counter}, 32'd3);

        // Reset in the middle of an update cycle.
        lookup_valid = 1; update_enable = 1; update_pc = 32'h40; update_history = 4'b0110; taken = 0;
        apply_reset();
        lookup(32'h40, 4'b0110);

        apply_reset();
        for (int i = 0; i < 10; i++)
            cycle(1, 0, i * 4, 4'(i), (i < 6), 32'h100 + i * 4, 4'hC, i[0], (i == 1 || i == 4));
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("stat_l10", stat_lookups, 32'd10);
        check("stat_u6", stat_updates, 32'd6);
        check("stat_m2", stat_mispredicts, 32'd2);

        force dut.r_stat_updates = 32'hFFFFFFFF;
        #1 release dut.r_stat_updates;
        e_u = 32'hFFFFFFFF;
        train(32'h0, 4'h0, 1);
        train(32'h0, 4'h0, 0);

        // Random traffic over a small index space to exercise collisions.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  32'($urandom_range(0, 3)) << 2, 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)) << 2,
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_history_table.md
# pattern_history_table

Second level of the two-level local branch predictor. Takes the per-branch local history produced by the branch history table in IF, combines it with low PC bits, and looks up a table of 2-bit saturating counters to produce a registered taken/not-taken prediction. Trains the addressed counter when a branch resolves in EX and keeps saturating lookup, update and mispredict statistics.

## Interface
- HISTORY_BITS, 4, width of the local history input
- PC_INDEX_BITS, 4, PC bits concatenated above the history in the index
- INDEX_BITS, 8, must equal HISTORY_BITS + PC_INDEX_BITS
- TABLE_SIZE, 256, number of counters; must equal 2**INDEX_BITS
- COUNTER_INIT, 2'b01, counter value after reset (weakly not taken)

- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- lookup_valid  in  1  IF-stage lookup request
- stall  in  1  IF stall; freezes lookup capture and outputs
- pc  in  32  fetch PC of the lookup
- history  in  HISTORY_BITS  local history for pc, from the branch history table
- predict_valid  out  1  registered; prediction outputs are meaningful
- predict_taken  out  1  registered; MSB of the looked-up counter
- predict_counter  out  2  registered; full looked-up counter value
- update_enable  in  1  EX-stage branch resolution strobe
- update_pc  in  32  PC of the resolving branch
- update_history  in  HISTORY_BITS  history used when that branch was predicted, before shifting in its outcome
- taken  in  1  resolved outcome
- mispredicted  in  1  EX flag: prediction was wrong; counted only
- stat_lookups  out  32  accepted lookups, saturating
- stat_updates  out  32  updates, saturating
- stat_mispredicts  out  32  updates with mispredicted=1, saturating

## Operation
- Read index = {pc[PC_INDEX_BITS+1:2], history}; write index = {update_pc[PC_INDEX_BITS+1:2], update_history}. PC bits [1:0] and above PC_INDEX_BITS+1 ignored.
- Counter update when update_enable=1: taken=1 -> counter+1, saturates at 3; taken=0 -> counter-1, saturates at 0. Width stays 2 bits; no wrap from 3 to 0 or 0 to 3.
- Accepted lookup = lookup_valid && !stall. On accepted lookup, the addressed counter is captured into predict_counter; predict_taken = captured counter[1]; predict_valid <= 1.
- lookup_valid=0 && stall=0: predict_valid <= 0; predict_taken/predict_counter hold.
- stall=1: all three prediction outputs hold regardless of lookup_valid; no lookup counted.
- Bypass: accepted lookup and update_enable in the same cycle with equal read and write indices -> captured value is the post-update counter. Different indices -> lookup sees the pre-edge array value; update proceeds independently.
- Statistics: each increments by 1 on its event edge and holds at 32'hFFFFFFFF. stat_mispredicts ignores mispredicted when update_enable=0.
- Reset (reset_n low, async, any time including mid-update or mid-stall): all TABLE_SIZE counters <= COUNTER_INIT; predict_valid, predict_taken, predict_counter <= 0; all stats <= 0. The first edge after reset_n rises is a normal cycle.

## Timing
- Lookup latency: 1 cycle. Request at edge N -> outputs valid after edge N, usable in cycle N+1.
- Update latency: counter written at the edge where update_enable is sampled; a lookup at the next edge sees it. The same edge sees it through the bypass.
- One update and one lookup per cycle max; no back-pressure on update.
- Stats update at the same edge as their event; all outputs are registered.

## Test plan
- Reset: drive reset_n low for 2 cycles mid-traffic -> all outputs 0; lookup any index -> predict_counter=2'b01, predict_taken=0, predict_valid=1 one cycle later.
- Training/saturation: pc=0x40, history=4'b1010; 4 updates taken=1 -> counter 2,3,3,3; lookup -> predict_counter=3, predict_taken=1; 5 updates taken=0 -> lookup gives 0.
- Bypass: counter at index {4'h1,4'h3}=1; same cycle accepted lookup and update taken=1 on that index -> predict_counter=2, predict_taken=1. Repeat with a different lookup index -> lookup returns the old value of its own entry.
- Stall/idle: after a valid prediction, hold stall=1 for 3 cycles while changing pc/history -> outputs unchanged, stat_lookups unchanged; then lookup_valid=0, stall=0 -> predict_valid=0, predict_counter held.
- Indexing: same pc, histories 4'b0000 and 4'b1111 trained opposite directions -> independent predictions; pc 0x40 vs 0x440, same history -> alias to the same entry.
- Stats: 10 lookups, 6 updates with 2 mispredicted, plus 1 mispredicted=1 without update_enable -> stat_lookups=10, stat_updates=6, stat_mispredicts=2; force stat_updates to 32'hFFFFFFFF, then update -> stays 32'hFFFFFFFF.
